// File: rtl/fetch_pkg.sv
// Shared definitions for the byte fetch unit: fetch modes, maximum
// instruction length, compact-mode length codes and the length decoder.
package fetch_pkg;

  localparam logic MODE_MIPS    = 1'b0;
  localparam logic MODE_COMPACT = 1'b1;

  localparam int MAXLEN = 6;

  // Compact-mode length codes carried in the top two bits of the first byte
  localparam logic [1:0] LC_2B = 2'b00;
  localparam logic [1:0] LC_3B = 2'b01;
  localparam logic [1:0] LC_4B = 2'b10;
  localparam logic [1:0] LC_6B = 2'b11;

  // Instruction length in bytes from the fetch mode and the head byte
  function automatic logic [2:0] inst_length(input logic mode, input logic [7:0] b0);
    logic [2:0] len;
    len = 3'd4;
    if (mode == MODE_MIPS) begin
      len = 3'd4;
    end else begin
      case (b0[7:6])
        LC_2B:   len = 3'd2;
        LC_3B:   len = 3'd3;
        LC_4B:   len = 3'd4;
        LC_6B:   len = 3'd6;
        default: len = 3'd4;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/byte_queue.sv
// Circular byte buffer: one-byte push, variable-length pop (1..MAXLEN),
// a MAXLEN-byte peek window starting at the read pointer, and flush.
module byte_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [7:0]                  push_data_i,
  input  logic                        pop_i,
  input  logic [2:0]                  pop_len_i,
  output logic [MAXLEN-1:0][7:0]      peek_o,
  output logic [$clog2(QDEPTH):0]     count_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    pop_amt_s;

  // Pointer and occupancy next-state; flush discards everything queued
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    pop_amt_s = pop_i ? pop_len_i : 3'd0;
    if (flush_i) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push_i) begin
        wptr_d = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      rptr_d  = rptr_q + PW'(pop_amt_s);
      count_d = count_q + CW'(push_i) - CW'(pop_amt_s);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Byte storage; a flush cycle never writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_i && !flush_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  // Peek window: the next MAXLEN bytes from the read pointer, wrapping
  always_comb begin
    for (int k = 0; k < MAXLEN; k++) begin
      peek_o[k] = mem_q[rptr_q + PW'(k)];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/byte_fetch_unit.sv
// Byte fetch unit: streams bytes from a byte-wide instruction memory into a
// small queue and presents whole variable-length instructions to decode.
// Optional macro FETCH_PERF_EN adds perf_insts / perf_bubbles counters.
module byte_fetch_unit
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] pc,
  input  logic [7:0]  instmem_dataout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_mode,
  output logic [47:0] inst,
  output logic [2:0]  inst_len,
  output logic [31:0] inst_pc,
  output logic [31:0] next_inst_pc,
  output logic        inst_mode,
  output logic        inst_valid,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_insts,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]            fpc_q, fpc_d;
  logic [31:0]            head_pc_q, head_pc_d;
  logic                   mode_q, mode_d;
  logic [CW-1:0]          count_s;
  logic [MAXLEN-1:0][7:0] peek_s;
  logic [MAXLEN-1:0][7:0] bytes_s;
  logic [2:0]             len_s;
  logic                   valid_s;
  logic                   push_s;
  logic                   pop_s;
  logic [47:0]            inst_s;

  byte_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .resetn      (resetn),
    .flush_i     (redirect),
    .push_i      (push_s),
    .push_data_i (instmem_dataout),
    .pop_i       (pop_s),
    .pop_len_i   (len_s),
    .peek_o      (peek_s),
    .count_o     (count_s)
  );

  // Only resident bytes are visible; anything at or past count reads as zero
  always_comb begin
    for (int k = 0; k < MAXLEN; k++) begin
      bytes_s[k] = (count_s > CW'(k)) ? peek_s[k] : 8'h00;
    end
  end

  assign len_s   = inst_length(mode_q, bytes_s[0]);
  assign valid_s = (count_s >= {{(CW-3){1'b0}}, len_s}) & ~redirect;
  // Push eligibility looks only at the registered count, not a same-cycle pop
  assign push_s  = (count_s < CW'(QDEPTH)) & ~redirect;
  assign pop_s   = valid_s & inst_ready;

  // Right-justified big-endian packing: byte 0 is the most significant
  always_comb begin
    int base;
    inst_s = 48'h0;
    base   = 0;
    for (int k = 0; k < MAXLEN; k++) begin
      if (k < int'(len_s)) begin
        base = 8 * (int'(len_s) - 1 - k);
        inst_s[base +: 8] = bytes_s[k];
      end else begin
        base = 0;  // bytes past the length belong to the next instruction
      end
    end
  end

  // Fetch address, head address and mode next-state; redirect overrides all
  always_comb begin
    fpc_d     = fpc_q;
    head_pc_d = head_pc_q;
    mode_d    = mode_q;
    if (redirect) begin
      fpc_d     = redirect_pc;
      head_pc_d = redirect_pc;
      mode_d    = redirect_mode;
    end else begin
      if (push_s) begin
        fpc_d = fpc_q + 32'd1;
      end else begin
        fpc_d = fpc_q;
      end
      if (pop_s) begin
        head_pc_d = head_pc_q + {29'd0, len_s};
      end else begin
        head_pc_d = head_pc_q;
      end
    end
  end

  // Fetch address, head address and mode registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fpc_q     <= 32'h0;
      head_pc_q <= 32'h0;
      mode_q    <= MODE_MIPS;
    end else begin
      fpc_q     <= fpc_d;
      head_pc_q <= head_pc_d;
      mode_q    <= mode_d;
    end
  end

  assign pc           = fpc_q;
  assign inst         = inst_s;
  assign inst_len     = len_s;
  assign inst_pc      = head_pc_q;
  assign next_inst_pc = head_pc_q + {29'd0, len_s};
  assign inst_mode    = mode_q;
  assign inst_valid   = valid_s;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_insts_q;
  logic [31:0] perf_bubbles_q;

  // Delivered-instruction and starved-decode counters, wrapping silently
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_insts_q   <= 32'h0;
      perf_bubbles_q <= 32'h0;
    end else begin
      if (pop_s) begin
        perf_insts_q <= perf_insts_q + 32'd1;
      end
      if (inst_ready && !valid_s && !redirect) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_insts   = perf_insts_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_byte_fetch_unit.sv
// Self-checking bench for byte_fetch_unit. A byte-queue reference model
// (SV queue of bytes plus fetch/head addresses) predicts every output each
// cycle; directed scenarios add fixed expected values at key points.
module tb_byte_fetch_unit;

  localparam int QDEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc;
  logic [7:0]  instmem_dataout;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        redirect_mode = 1'b0;
  logic [47:0] inst;
  logic [2:0]  inst_len;
  logic [31:0] inst_pc;
  logic [31:0] next_inst_pc;
  logic        inst_mode;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_insts;
  logic [31:0] perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_fetch_unit #(.QDEPTH(QDEPTH)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .pc              (pc),
    .instmem_dataout (instmem_dataout),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .redirect_mode   (redirect_mode),
    .inst            (inst),
    .inst_len        (inst_len),
    .inst_pc         (inst_pc),
    .next_inst_pc    (next_inst_pc),
    .inst_mode       (inst_mode),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_insts      (perf_insts),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  // Instruction memory contents: 0 = low address byte, 1 = directed compact
  // pattern, 2 = random table
  int         rom_sel = 0;
  logic [7:0] rnd_mem [256];

  function automatic logic [7:0] rom_ref(input logic [31:0] a);
    if (rom_sel == 1) begin
      if (a == 32'h100) return 8'hC5;
      if (a == 32'h106) return 8'h12;
      return a[7:0];
    end
    if (rom_sel == 2) return rnd_mem[a[7:0]];
    return a[7:0];
  endfunction

  always_comb begin
    if (rom_sel == 1) begin
      instmem_dataout = (pc == 32'h100) ? 8'hC5 : (pc == 32'h106) ? 8'h12 : pc[7:0];
    end else if (rom_sel == 2) begin
      instmem_dataout = rnd_mem[pc[7:0]];
    end else begin
      instmem_dataout = pc[7:0];
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  logic [31:0] m_fpc, m_head;
  logic        m_mode;
  logic [31:0] m_perf_i, m_perf_b;
  logic [2:0]  lenmap [4] = '{3'd2, 3'd3, 3'd4, 3'd6};

  logic        e_valid;
  logic [2:0]  e_len;
  logic [47:0] e_inst;
  logic [148:0] exp_w;
  wire  [148:0] got_w = {inst_valid, inst, inst_len, inst_pc, next_inst_pc, inst_mode, pc};

  task automatic model_reset();
    mq.delete();
    m_fpc = 32'h0; m_head = 32'h0; m_mode = 1'b0;
    m_perf_i = 32'h0; m_perf_b = 32'h0;
  endtask

  task automatic model_eval();
    int n;
    logic [7:0] b0;
    n = mq.size();
    b0 = (n > 0) ? mq[0] : 8'h00;
    e_len = m_mode ? lenmap[b0[7:6]] : 3'd4;
    e_valid = (n >= int'(e_len)) && !redirect;
    e_inst = 48'h0;
    for (int k = 0; k < int'(e_len) && k < n; k++) begin
      e_inst = e_inst | (48'(mq[k]) << (8 * (int'(e_len) - 1 - k)));
    end
    exp_w = {e_valid, e_inst, e_len, m_head, m_head + 32'(e_len), m_mode, m_fpc};
  endtask

  task automatic model_step();
    bit can_push;
    model_eval();
    if (redirect) begin
      mq.delete();
      m_fpc = redirect_pc; m_head = redirect_pc; m_mode = redirect_mode;
    end else begin
      can_push = (mq.size() < QDEPTH);
      if (e_valid && inst_ready) begin
        repeat (int'(e_len)) void'(mq.pop_front());
        m_head = m_head + 32'(e_len);
        m_perf_i = m_perf_i + 32'd1;
      end
      if (inst_ready && !e_valid) m_perf_b = m_perf_b + 32'd1;
      if (can_push) begin
        mq.push_back(rom_ref(m_fpc));
        m_fpc = m_fpc + 32'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    redirect = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rom_sel = 0;
    inst_ready = 1'b1;
    apply_reset();
    #1;
    checks++;
    if (got_w !== {1'b0, 48'h0, 3'd4, 32'h0, 32'h4, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_state got %h exp %h", got_w, {1'b0, 48'h0, 3'd4, 32'h0, 32'h4, 1'b0, 32'h0});
    end
    for (int i = 0; i < 10; i++) begin
      #1; model_eval();
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL mips_stream cyc %0d got %h exp %h", i, got_w, exp_w); end
      if (i == 4) begin
        checks++;
        if ({inst_valid, inst, inst_pc, next_inst_pc} !== {1'b1, 48'h000000010203, 32'h0, 32'h4}) begin
          errors++; $display("FAIL first_inst got v=%b inst=%h pc=%h npc=%h exp v=1 inst=000000010203 pc=0 npc=4", inst_valid, inst, inst_pc, next_inst_pc);
        end
      end
      if (i == 8) begin
        checks++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h4}) begin
          errors++; $display("FAIL second_inst got v=%b pc=%h exp v=1 pc=4", inst_valid, inst_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_compact();
    rom_sel = 1;
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h100; redirect_mode = 1'b1;
    #1; model_eval();
    checks++;
    if (got_w !== exp_w) begin errors++; $display("FAIL compact_redirect got %h exp %h", got_w, exp_w); end
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1; model_eval();
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL compact_stream cyc %0d got %h exp %h", i, got_w, exp_w); end
      if (i == 5 || i == 6 || i == 8) begin
        checks++;
        if (i == 5 && inst_valid !== 1'b0) begin errors++; $display("FAIL compact_early got v=%b exp 0", inst_valid); end
        if (i == 6 && {inst_valid, inst_len, next_inst_pc, inst} !== {1'b1, 3'd6, 32'h106, 48'hC50102030405}) begin
          errors++; $display("FAIL compact_len6 got v=%b len=%0d npc=%h inst=%h exp v=1 len=6 npc=106 inst=c50102030405", inst_valid, inst_len, next_inst_pc, inst);
        end
        if (i == 8 && {inst_valid, inst_len, inst} !== {1'b1, 3'd2, 48'h1207}) begin
          errors++; $display("FAIL compact_len2 got v=%b len=%0d inst=%h exp v=1 len=2 inst=1207", inst_valid, inst_len, inst);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rom_sel = 0;
    inst_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      #1; model_eval();
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL stall cyc %0d got %h exp %h", i, got_w, exp_w); end
      tick();
    end
    #1;
    checks++;
    if ({pc, inst_valid, inst} !== {32'h8, 1'b1, 48'h000000010203}) begin
      errors++; $display("FAIL full_hold got pc=%h v=%b inst=%h exp pc=8 v=1 inst=000000010203", pc, inst_valid, inst);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1; model_eval();
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL drain cyc %0d got %h exp %h", i, got_w, exp_w); end
      tick();
    end
  endtask

  task automatic test_redirect_partial();
    rom_sel = 0;
    inst_ready = 1'b1;
    apply_reset();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h40; redirect_mode = 1'b0;
    #1; model_eval();
    checks++;
    if (got_w !== exp_w || inst_valid !== 1'b0) begin errors++; $display("FAIL partial_redirect got %h exp %h", got_w, exp_w); end
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; model_eval();
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL partial_refill cyc %0d got %h exp %h", i, got_w, exp_w); end
      if (i == 4) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 48'h000040414243, 32'h40}) begin
          errors++; $display("FAIL partial_clean got v=%b inst=%h pc=%h exp v=1 inst=000040414243 pc=40", inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] saved_perf;
    int budget;
    rom_sel = 0;
    inst_ready = 1'b1;
    budget = 0;
    model_eval();
    while (!e_valid && budget < 20) begin
      tick(); budget++; model_eval();
    end
    checks++;
    if (!e_valid) begin errors++; $display("FAIL pop_wait timeout got no valid exp valid"); end
`ifdef FETCH_PERF_EN
    saved_perf = perf_insts;
`else
    saved_perf = 32'h0;
`endif
    redirect = 1'b1; redirect_pc = 32'h200; redirect_mode = 1'b1;
    #1; model_eval();
    checks++;
    if (got_w !== exp_w) begin errors++; $display("FAIL redirect_vs_pop got %h exp %h", got_w, exp_w); end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if ({inst_pc, inst_mode, inst_valid} !== {32'h200, 1'b1, 1'b0}) begin
      errors++; $display("FAIL redirect_head got pc=%h m=%b v=%b exp pc=200 m=1 v=0", inst_pc, inst_mode, inst_valid);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_insts !== saved_perf) begin errors++; $display("FAIL perf_no_pop got %0d exp %0d", perf_insts, saved_perf); end
`else
    if (saved_perf != 32'h0) $display("note: unexpected perf snapshot");
`endif
  endtask

  task automatic test_wrap();
    rom_sel = 0;
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; redirect_mode = 1'b0;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1; model_eval();
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL wrap cyc %0d got %h exp %h", i, got_w, exp_w); end
      if (i == 2) begin
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", pc); end
      end
      if (i == 4) begin
        checks++;
        if ({inst_valid, inst_pc, next_inst_pc, inst} !== {1'b1, 32'hFFFF_FFFE, 32'h2, 48'h0000FEFF0001}) begin
          errors++; $display("FAIL wrap_inst got v=%b pc=%h npc=%h inst=%h exp v=1 pc=fffffffe npc=2 inst=0000feff0001", inst_valid, inst_pc, next_inst_pc, inst);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    rom_sel = 2;
    for (int a = 0; a < 256; a++) rnd_mem[a] = 8'($urandom);
    inst_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      inst_ready = ($urandom % 4) != 0;
      redirect = ($urandom % 40) == 0;
      redirect_mode = 1'($urandom);
      case ($urandom % 3)
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF8 + ($urandom % 8);
        default: redirect_pc = $urandom % 512;
      endcase
      #1; model_eval();
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL random cyc %0d got %h exp %h", i, got_w, exp_w); end
`ifdef FETCH_PERF_EN
      checks++;
      if ({perf_insts, perf_bubbles} !== {m_perf_i, m_perf_b}) begin
        errors++; $display("FAIL perf cyc %0d got %0d/%0d exp %0d/%0d", i, perf_insts, perf_bubbles, m_perf_i, m_perf_b);
      end
`endif
      tick();
    end
    redirect = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_redirect_compact();
    test_backpressure();
    test_redirect_partial();
    test_redirect_pop();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
